// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 responder over a 64-bit 1R1W word array
// Optional beat address range check: define SRAM_SLV_RANGE_CHECK_EN.
module axi4_sram_slave #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_LATENCY = 1,
  parameter int          ID_WIDTH   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         awaddr,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [7:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic [63:0]         wdata,
  input  logic [7:0]          wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [ID_WIDTH-1:0] bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [31:0]         araddr,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [7:0]          arlen,
  output logic                rvalid,
  input  logic                rready,
  output logic [63:0]         rdata,
  output logic [1:0]          rresp,
  output logic [ID_WIDTH-1:0] rid,
  output logic                rlast
);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

  wr_state_t   wr_state, wr_next;
  rd_state_t   rd_state, rd_next;
  logic [63:0] mem [DEPTH];
  logic [31:0] wr_addr, rd_addr;
  logic [8:0]  wr_cnt, rd_cnt;
  logic [3:0]  rd_wait;
  logic        aw_hs, w_hs, ar_hs, r_hs, rd_fetch, w_err, rd_err;
  logic        unused;

`ifdef SRAM_SLV_RANGE_CHECK_EN
  function automatic logic out_of_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off >= (33'd8 << DEPTH_LOG2);
  endfunction
  assign w_err  = out_of_range(wr_addr);
  assign rd_err = out_of_range(rd_addr);
`else
  assign w_err  = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign unused   = &{1'b0, wlast, BASE_ADDR, wr_addr, rd_addr};
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign ar_hs    = arvalid && arready;
  assign r_hs     = rvalid && rready;
  // Fetch the next word when the output register is empty or being drained mid-burst.
  assign rd_fetch = (rd_state == RD_DATA) && (!rvalid || (rready && !rlast));

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (awvalid) wr_next = WR_DATA;
      WR_DATA: if (wvalid && wr_cnt == 9'd1) wr_next = WR_RESP;
      WR_RESP: if (bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (arvalid) rd_next = (RD_LATENCY == 0) ? RD_DATA : RD_WAIT;
      RD_WAIT: if (rd_wait == 4'd0) rd_next = RD_DATA;
      RD_DATA: if (rvalid && rready && rlast) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    awready = (wr_state == WR_IDLE);
    wready  = (wr_state == WR_DATA);
    bvalid  = (wr_state == WR_RESP);
    arready = (rd_state == RD_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_addr <= '0;
      wr_cnt  <= '0;
      bid     <= '0;
      bresp   <= 2'b00;
    end else if (aw_hs) begin
      wr_addr <= awaddr;
      wr_cnt  <= {1'b0, awlen} + 9'd1;
      bid     <= awid;
      bresp   <= 2'b00;
    end else if (w_hs) begin
      wr_addr <= wr_addr + 32'd8;
      wr_cnt  <= wr_cnt - 9'd1;
      if (w_err) bresp <= 2'b10;
    end
  end

  // Array is deliberately left out of reset; the reset gate only blocks a write on the reset edge.
  always_ff @(posedge clock) begin
    if (reset && w_hs && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[wr_addr[DEPTH_LOG2+2:3]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_addr <= '0;
      rd_cnt  <= '0;
      rd_wait <= '0;
      rid     <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      if (ar_hs) begin
        rd_addr <= araddr;
        rd_cnt  <= {1'b0, arlen} + 9'd1;
        rd_wait <= WAIT_INIT;
        rid     <= arid;
      end else if (rd_state == RD_WAIT && rd_wait != 4'd0) begin
        rd_wait <= rd_wait - 4'd1;
      end
      if (rd_fetch) begin
        rvalid  <= 1'b1;
        rlast   <= (rd_cnt == 9'd1);
        rd_cnt  <= rd_cnt - 9'd1;
        rd_addr <= rd_addr + 32'd8;
        if (rd_err) begin
          rdata <= '0;
          rresp <= 2'b10;
        end else begin
          rdata <= mem[rd_addr[DEPTH_LOG2+2:3]];
          rresp <= 2'b00;
        end
      end else if (r_hs && rlast) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - self-checking bench for axi4_sram_slave
// Honours SRAM_SLV_RANGE_CHECK_EN in its reference model.
module tb_axi4_sram_slave;
  localparam int          DL   = 12;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          RL   = 1;
`ifdef SRAM_SLV_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b0;
  logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [31:0] awaddr = 0, araddr = 0;
  logic [3:0]  awid = 0, bid, arid = 0, rid;
  logic [7:0]  awlen = 0, arlen = 0, wstrb = 0;
  logic [63:0] wdata = 0, rdata;
  logic [1:0]  bresp, rresp;

  logic [63:0] ref_mem [1 << DL];
  int tests = 0, fails = 0;

  axi4_sram_slave #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .RD_LATENCY(RL), .ID_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < (32'd8 << DL));
  endfunction

  // Merge one beat into the reference array; returns 1 when the beat is an error beat.
  function automatic bit model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    if (CHK && !in_rng(a)) return 1'b1;
    for (int i = 0; i < 8; i++)
      if (s[i]) ref_mem[a[DL+2:3]][8*i +: 8] = d[8*i +: 8];
    return 1'b0;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input logic [63:0] d0, input logic [7:0] s0,
                          input bit rnd_data, input bit rnd_strb, input int bhold);
    logic [1:0]  eresp = 2'b00;
    logic [63:0] d;
    logic [7:0]  s;
    check("aw_ready_idle", awready, 1);
    awvalid = 1; awaddr = addr; awid = id; awlen = len[7:0];
    @(negedge clock);
    awvalid = 0;
    for (int k = 0; k <= len; k++) begin
      if (rnd_data && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
      d = rnd_data ? {$urandom, $urandom} : d0;
      s = rnd_strb ? 8'($urandom_range(0, 255)) : s0;
      check("w_ready", wready, 1);
      wvalid = 1; wdata = d; wstrb = s; wlast = (k == len);
      if (model_write(addr + 32'(8 * k), d, s)) eresp = 2'b10;
      @(negedge clock);
      wvalid = 0; wlast = 0;
    end
    check("b_valid", bvalid, 1);
    check("b_id", bid, id);
    check("b_resp", bresp, eresp);
    for (int h = 0; h < bhold; h++) begin
      awvalid = 1; awid = ~id;
      @(negedge clock);
      check("b_hold_valid", bvalid, 1);
      check("b_hold_id", bid, id);
      check("b_hold_awready", awready, 0);
    end
    awvalid = 0;
    bready = 1;
    @(negedge clock);
    bready = 0;
    check("b_done_valid", bvalid, 0);
    check("b_done_awready", awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id, input bit directed);
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int n = 0, beat = 0, step = 0;
    logic [31:0] a;
    logic [63:0] ed;
    logic [1:0]  er;
    check("ar_ready_idle", arready, 1);
    arvalid = 1; araddr = addr; arid = id; arlen = len[7:0];
    @(negedge clock);
    arvalid = 0;
    while (!rvalid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("r_latency", 64'(n), 64'(1 + RL));
    while (beat <= len && step < 200) begin
      a = addr + 32'(8 * beat);
      if (CHK && !in_rng(a)) begin ed = '0; er = 2'b10; end
      else begin ed = ref_mem[a[DL+2:3]]; er = 2'b00; end
      check("r_valid", rvalid, 1);
      check("r_data", rdata, ed);
      check("r_resp", rresp, er);
      check("r_id", rid, id);
      check("r_last", rlast, beat == len);
      rready = directed ? (step < 5 ? pat[step] : 1'b1) : ($urandom_range(0, 2) != 0);
      step++;
      @(negedge clock);
      if (rready) beat++;
    end
    rready = 0;
    check("r_done_valid", rvalid, 0);
    check("r_done_arready", arready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_ids", {bid, rid}, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    reset = 1;
    @(negedge clock);

    // Initialise words 0..63 and 4094..4095 so every later read is defined.
    do_write(BASE, 63, 4'h1, 0, 8'hFF, 1, 0, 0);
    do_write(BASE + 32'h7FF0, 1, 4'h2, 0, 8'hFF, 1, 0, 0);

    do_write(BASE + 32'h10, 0, 4'h3, 64'h0, 8'hFF, 0, 0, 0);
    do_write(BASE + 32'h13, 0, 4'h5, 64'h0000_0000_AB00_0000, 8'h08, 0, 0, 0);
    do_read(BASE + 32'h10, 0, 4'h6, 0);

    do_read(BASE + 32'h20, 3, 4'h9, 1);

    do_write(BASE + 32'h40, 1, 4'hA, 0, 8'hFF, 1, 1, 5);

    // Write and read fetch of word 9 land on the same edge.
    do_write(BASE + 32'h48, 0, 4'h1, 64'h11, 8'hFF, 0, 0, 0);
    awvalid = 1; awaddr = BASE + 32'h48; awid = 4'h7; awlen = 0;
    arvalid = 1; araddr = BASE + 32'h48; arid = 4'hC; arlen = 0;
    @(negedge clock);
    awvalid = 0; arvalid = 0;
    repeat (RL) @(negedge clock);
    wvalid = 1; wdata = 64'h22; wstrb = 8'hFF; wlast = 1;
    @(negedge clock);
    wvalid = 0; wlast = 0;
    check("same_rvalid", rvalid, 1);
    check("same_old_data", rdata, 64'h11);
    check("same_bvalid", bvalid, 1);
    rready = 1; bready = 1;
    @(negedge clock);
    rready = 0; bready = 0;
    void'(model_write(BASE + 32'h48, 64'h22, 8'hFF));
    do_read(BASE + 32'h48, 0, 4'hD, 0);

    // Top-of-array wrap and below-base alias.
    do_write(BASE + 32'h7FF0, 3, 4'hE, 0, 0, 1, 1, 0);
    do_read(BASE + 32'h7FF0, 3, 4'hF, 0);
    do_read(BASE - 32'd8, 0, 4'h4, 0);

    for (int it = 0; it < 24; it++) begin
      do_write(BASE + 32'(8 * $urandom_range(0, 56)) + 32'($urandom_range(0, 7)),
               $urandom_range(0, 7), 4'($urandom), 0, 0, 1, 1, $urandom_range(0, 2));
      do_read(BASE + 32'(8 * $urandom_range(0, 56)) + 32'($urandom_range(0, 7)),
              $urandom_range(0, 7), 4'($urandom), 0);
    end

    // Reset mid write burst: two beats land, no B follows.
    awvalid = 1; awaddr = BASE + 32'(8 * 40); awid = 4'h3; awlen = 3;
    @(negedge clock);
    awvalid = 0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1; wdata = {$urandom, $urandom}; wstrb = 8'hFF;
      void'(model_write(BASE + 32'(8 * (40 + k)), wdata, wstrb));
      @(negedge clock);
    end
    wvalid = 0;
    reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("abort_w_bvalid", bvalid, 0);
    check("abort_w_wready", wready, 0);
    check("abort_w_awready", awready, 1);
    do_read(BASE + 32'(8 * 40), 3, 4'h2, 0);

    // Reset mid read burst: R stops.
    arvalid = 1; araddr = BASE; arid = 4'h5; arlen = 7;
    @(negedge clock);
    arvalid = 0;
    repeat (RL + 1) @(negedge clock);
    check("abort_r_started", rvalid, 1);
    reset = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("abort_r_rvalid", rvalid, 0);
    check("abort_r_rlast", rlast, 0);
    check("abort_r_arready", arready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
